core_c1_exu_alu_sched: RTL and testbench

CORE_C1_EXU_ALU_SCHED -- requirements
Module: core_c1_exu_alu_sched

---
 rtl/core_c1_exu_alu_sched.sv | 150 +++++++++++++++
 tb/tb_core_c1_exu_alu_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_c1_exu_alu_sched.sv
// Issue scheduler for two requesters sharing one combinational ALU.
// S1 holds the granted instruction and drives the ALU; S2 registers the ALU
// result for the writeback consumer under a valid/ready handshake.
module core_c1_exu_alu_sched #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [31:0] rq0_pc_addr,
  input  logic [31:0] rq0_rs1_data,
  input  logic [31:0] rq0_rs2_data,
  input  logic [31:0] rq0_imm32,
  input  logic [7:0]  rq0_type_bus,
  input  logic [11:0] rq0_op_alu,
  input  logic [4:0]  rq0_rd_idx,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic [31:0] rq1_pc_addr,
  input  logic [31:0] rq1_rs1_data,
  input  logic [31:0] rq1_rs2_data,
  input  logic [31:0] rq1_imm32,
  input  logic [7:0]  rq1_type_bus,
  input  logic [11:0] rq1_op_alu,
  input  logic [4:0]  rq1_rd_idx,
  output logic [31:0] alu_pc_addr,
  output logic [31:0] alu_rs1_data,
  output logic [31:0] alu_rs2_data,
  output logic [31:0] alu_imm32,
  output logic [7:0]  alu_type_bus,
  output logic [11:0] alu_op_alu,
  input  logic [31:0] alu_rd_data,
  input  logic        alu_rd_valid,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_wen,
  output logic [4:0]  res_rd_idx,
  output logic        res_src,
  output logic        busy
);

  typedef struct packed {
    logic [31:0] pc_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm32;
    logic [7:0]  type_bus;
    logic [11:0] op_alu;
    logic [4:0]  rd_idx;
  } issue_t;

  issue_t s1_pay;
  issue_t in_pay;
  logic   s1_valid;
  logic   s1_src;
  logic   last_grant;
  logic   grant0;
  logic   grant1;
  logic   adv;
  logic   acc_ok;
  logic   acc;

  // Arbitrate between the two requesters (round-robin or fixed priority).
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rq0_valid && rq1_valid) begin
      if (RR_EN && !last_grant) grant1 = 1'b1;
      else                      grant0 = 1'b1;
    end else if (rq0_valid) begin
      grant0 = 1'b1;
    end else if (rq1_valid) begin
      grant1 = 1'b1;
    end
  end

  // S1 drains into S2 whenever S2 is empty or being consumed this cycle.
  assign adv       = s1_valid && (!res_valid || res_ready);
  assign acc_ok    = (!s1_valid || adv) && !flush && !rst;
  assign rq0_ready = grant0 && acc_ok;
  assign rq1_ready = grant1 && acc_ok;
  assign acc       = rq0_ready || rq1_ready;

  // Steer the granted requester's payload toward S1.
  always_comb begin
    in_pay = '{pc_addr: rq0_pc_addr, rs1_data: rq0_rs1_data, rs2_data: rq0_rs2_data,
               imm32: rq0_imm32, type_bus: rq0_type_bus, op_alu: rq0_op_alu,
               rd_idx: rq0_rd_idx};
    if (grant1) begin
      in_pay = '{pc_addr: rq1_pc_addr, rs1_data: rq1_rs1_data, rs2_data: rq1_rs2_data,
                 imm32: rq1_imm32, type_bus: rq1_type_bus, op_alu: rq1_op_alu,
                 rd_idx: rq1_rd_idx};
    end
  end

  // Pipeline control, S2 result register and arbitration history.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      s1_valid   <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_wen    <= 1'b0;
      res_rd_idx <= '0;
      res_src    <= 1'b0;
      last_grant <= 1'b1;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (adv) begin
        res_valid  <= 1'b1;
        res_data   <= alu_rd_data;
        res_wen    <= alu_rd_valid;
        res_rd_idx <= s1_pay.rd_idx;
        res_src    <= s1_src;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (acc) begin
        s1_valid   <= 1'b1;
        last_grant <= grant1;
      end else if (adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // S1 payload capture on an accepted handshake.
  always_ff @(posedge clk) begin
    // NOTE: the payload is not reset; s1_valid qualifies it and the ALU outputs are masked while it is low.
    if (acc) begin
      s1_pay <= in_pay;
      s1_src <= grant1;
    end
  end

  assign alu_pc_addr  = s1_valid ? s1_pay.pc_addr  : '0;
  assign alu_rs1_data = s1_valid ? s1_pay.rs1_data : '0;
  assign alu_rs2_data = s1_valid ? s1_pay.rs2_data : '0;
  assign alu_imm32    = s1_valid ? s1_pay.imm32    : '0;
  assign alu_type_bus = s1_valid ? s1_pay.type_bus : '0;
  assign alu_op_alu   = s1_valid ? s1_pay.op_alu   : '0;
  assign busy         = s1_valid || res_valid;

endmodule

// File: tb/tb_core_c1_exu_alu_sched.sv
// Scoreboard bench: an issue-side process predicts grants and queues expected
// results; a separate monitor pops and compares whenever a result is consumed.
// A second instance with fixed priority shares all stimulus.
module tb_core_c1_exu_alu_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        res_ready = 1'b0;
  logic        r_valid [2] = '{1'b0, 1'b0};
  logic [31:0] r_pc [2], r_rs1 [2], r_rs2 [2], r_imm [2];
  logic [7:0]  r_ty [2];
  logic [11:0] r_op [2];
  logic [4:0]  r_rd [2];

  logic        rq0_ready, rq1_ready, res_valid, res_wen, res_src, busy, alu_rd_valid;
  logic [31:0] alu_pc_addr, alu_rs1_data, alu_rs2_data, alu_imm32, alu_rd_data, res_data;
  logic [7:0]  alu_type_bus;
  logic [11:0] alu_op_alu;
  logic [4:0]  res_rd_idx;

  logic        fp_rq0_ready, fp_rq1_ready, fp_res_valid, fp_res_wen, fp_res_src, fp_busy, fp_alu_rd_valid;
  logic [31:0] fp_alu_pc_addr, fp_alu_rs1_data, fp_alu_rs2_data, fp_alu_imm32, fp_alu_rd_data, fp_res_data;
  logic [7:0]  fp_alu_type_bus;
  logic [11:0] fp_alu_op_alu;
  logic [4:0]  fp_res_rd_idx;

  typedef struct {
    logic [31:0] data;
    logic        wen;
    logic [4:0]  rd;
    logic        src;
    int          cyc;
    bit          exact;
  } item_t;

  item_t q[$];
  bit    last_grant_m = 1'b1;
  bit    exact_phase = 1'b0;
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: the shared execution unit as seen by the scheduler.
  function automatic logic [32:0] alu_fn(input logic [31:0] pc, input logic [31:0] rs1,
                                         input logic [31:0] rs2, input logic [31:0] imm,
                                         input logic [7:0] ty, input logic [11:0] op);
    logic [31:0] b;
    b = ty[1] ? imm : rs2;
    if (op[11]) return {1'b1, imm};
    if (op[10]) return {1'b1, pc + imm};
    if (op[9])  return {1'b1, rs1 + b};
    if (op[8])  return {1'b1, rs1 - b};
    if (op[7])  return {1'b1, rs1 & b};
    if (op[6])  return {1'b1, rs1 | b};
    if (op[5])  return {1'b1, rs1 ^ b};
    if (op[4])  return {1'b1, rs1 << b[4:0]};
    if (op[3])  return {1'b1, 31'd0, $signed(rs1) < $signed(b)};
    if (op[2])  return {1'b1, 31'd0, rs1 < b};
    if (op[1])  return {1'b1, rs1 >> b[4:0]};
    if (op[0])  return {1'b1, 32'($signed(rs1) >>> b[4:0])};
    return 33'd0;
  endfunction

  assign {alu_rd_valid, alu_rd_data} =
    alu_fn(alu_pc_addr, alu_rs1_data, alu_rs2_data, alu_imm32, alu_type_bus, alu_op_alu);
  assign {fp_alu_rd_valid, fp_alu_rd_data} =
    alu_fn(fp_alu_pc_addr, fp_alu_rs1_data, fp_alu_rs2_data, fp_alu_imm32, fp_alu_type_bus, fp_alu_op_alu);

  core_c1_exu_alu_sched #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rq0_valid(r_valid[0]), .rq0_ready(rq0_ready), .rq0_pc_addr(r_pc[0]),
    .rq0_rs1_data(r_rs1[0]), .rq0_rs2_data(r_rs2[0]), .rq0_imm32(r_imm[0]),
    .rq0_type_bus(r_ty[0]), .rq0_op_alu(r_op[0]), .rq0_rd_idx(r_rd[0]),
    .rq1_valid(r_valid[1]), .rq1_ready(rq1_ready), .rq1_pc_addr(r_pc[1]),
    .rq1_rs1_data(r_rs1[1]), .rq1_rs2_data(r_rs2[1]), .rq1_imm32(r_imm[1]),
    .rq1_type_bus(r_ty[1]), .rq1_op_alu(r_op[1]), .rq1_rd_idx(r_rd[1]),
    .alu_pc_addr(alu_pc_addr), .alu_rs1_data(alu_rs1_data), .alu_rs2_data(alu_rs2_data),
    .alu_imm32(alu_imm32), .alu_type_bus(alu_type_bus), .alu_op_alu(alu_op_alu),
    .alu_rd_data(alu_rd_data), .alu_rd_valid(alu_rd_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_wen(res_wen),
    .res_rd_idx(res_rd_idx), .res_src(res_src), .busy(busy)
  );

  core_c1_exu_alu_sched #(.RR_EN(1'b0)) fp (
    .clk(clk), .rst(rst), .flush(flush),
    .rq0_valid(r_valid[0]), .rq0_ready(fp_rq0_ready), .rq0_pc_addr(r_pc[0]),
    .rq0_rs1_data(r_rs1[0]), .rq0_rs2_data(r_rs2[0]), .rq0_imm32(r_imm[0]),
    .rq0_type_bus(r_ty[0]), .rq0_op_alu(r_op[0]), .rq0_rd_idx(r_rd[0]),
    .rq1_valid(r_valid[1]), .rq1_ready(fp_rq1_ready), .rq1_pc_addr(r_pc[1]),
    .rq1_rs1_data(r_rs1[1]), .rq1_rs2_data(r_rs2[1]), .rq1_imm32(r_imm[1]),
    .rq1_type_bus(r_ty[1]), .rq1_op_alu(r_op[1]), .rq1_rd_idx(r_rd[1]),
    .alu_pc_addr(fp_alu_pc_addr), .alu_rs1_data(fp_alu_rs1_data), .alu_rs2_data(fp_alu_rs2_data),
    .alu_imm32(fp_alu_imm32), .alu_type_bus(fp_alu_type_bus), .alu_op_alu(fp_alu_op_alu),
    .alu_rd_data(fp_alu_rd_data), .alu_rd_valid(fp_alu_rd_valid),
    .res_valid(fp_res_valid), .res_ready(res_ready), .res_data(fp_res_data), .res_wen(fp_res_wen),
    .res_rd_idx(fp_res_rd_idx), .res_src(fp_res_src), .busy(fp_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(input int n, input logic v);
    r_valid[n] = v;
    r_pc[n]    = $urandom;
    r_rs1[n]   = $urandom;
    r_rs2[n]   = $urandom;
    r_imm[n]   = $urandom;
    r_ty[n]    = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
    r_op[n]    = ($urandom_range(0, 9) == 0) ? 12'h000 : 12'(1 << $urandom_range(0, 11));
    r_rd[n]    = 5'($urandom);
  endtask

  // Issue side: predict acceptance and grant, then queue the expected result.
  // In-flight count alone decides acceptance: one or zero held means S1 is or
  // becomes free; two held means both stages are full and only a consume frees S1.
  always @(negedge clk) begin : issue_side
    bit          acc_ok_m;
    int          win;
    item_t       it;
    logic [32:0] r;
    acc_ok_m = !rst && !flush && (q.size() < 2 || res_ready);
    win = -1;
    if (r_valid[0] && r_valid[1]) win = last_grant_m ? 0 : 1;
    else if (r_valid[0])          win = 0;
    else if (r_valid[1])          win = 1;
    check("rr_ready0", rq0_ready, acc_ok_m && win == 0);
    check("rr_ready1", rq1_ready, acc_ok_m && win == 1);
    check("fp_ready0", fp_rq0_ready, acc_ok_m && r_valid[0]);
    check("fp_ready1", fp_rq1_ready, acc_ok_m && r_valid[1] && !r_valid[0]);
    if (!rst) begin
      check("busy", busy, q.size() != 0);
      if (q.size() == 0) check("alu_idle", |{alu_pc_addr, alu_rs1_data, alu_rs2_data,
                                             alu_imm32, alu_type_bus, alu_op_alu}, 1'b0);
      if (q.size() == 2) check("s2_full", res_valid, 1'b1);
    end
    if (rst) begin
      q.delete();
      last_grant_m = 1'b1;
    end else if (flush) begin
      q.delete();
    end else if (acc_ok_m && win >= 0) begin
      r = alu_fn(r_pc[win], r_rs1[win], r_rs2[win], r_imm[win], r_ty[win], r_op[win]);
      it.data  = r[31:0];
      it.wen   = r[32];
      it.rd    = r_rd[win];
      it.src   = (win == 1);
      it.cyc   = cyc;
      it.exact = exact_phase;
      q.push_back(it);
      last_grant_m = (win == 1);
    end
  end

  // Result monitor: compare each consumed result and hold stability under backpressure.
  bit          hold_chk = 1'b0;
  logic [31:0] held_data;
  logic [4:0]  held_rd;
  logic        held_wen, held_src;

  always @(negedge clk) begin : monitor
    item_t it;
    int    lat;
    #1;
    if (hold_chk) begin
      check("hold_valid", res_valid, 1'b1);
      check("hold_data", res_data, held_data);
      check("hold_meta", {res_wen, res_rd_idx, res_src}, {held_wen, held_rd, held_src});
    end
    if (!rst && !flush && res_valid && res_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", 1'b1, 1'b0);
      end else begin
        it  = q.pop_front();
        lat = cyc - it.cyc;
        check("res_data", res_data, it.data);
        check("res_wen", res_wen, it.wen);
        check("res_rd_idx", res_rd_idx, it.rd);
        check("res_src", res_src, it.src);
        if (it.exact) check("latency", lat, 2);
        else          check("latency_min", lat >= 2, 1'b1);
      end
    end
    hold_chk  = !rst && !flush && res_valid && !res_ready;
    held_data = res_data;
    held_rd   = res_rd_idx;
    held_wen  = res_wen;
    held_src  = res_src;
  end

  initial begin
    rand_req(0, 1'b0);
    rand_req(1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_fields", {res_data, res_wen, res_rd_idx, res_src}, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_alu", |{alu_pc_addr, alu_rs1_data, alu_rs2_data, alu_imm32, alu_type_bus, alu_op_alu}, 1'b0);
    step();
    rst = 1'b0;

    // Single ADD from requester 0, result two edges later.
    res_ready = 1'b1;
    exact_phase = 1'b1;
    r_valid[0] = 1'b1; r_pc[0] = 32'h0; r_rs1[0] = 32'd5; r_rs2[0] = 32'd7;
    r_imm[0] = 32'h0; r_ty[0] = 8'h01; r_op[0] = 12'h200; r_rd[0] = 5'd3;
    step();
    r_valid[0] = 1'b0;
    step();
    check("add_valid", res_valid, 1'b1);
    check("add_data", res_data, 32'd12);
    check("add_meta", {res_wen, res_rd_idx, res_src}, {1'b1, 5'd3, 1'b0});
    repeat (3) step();

    // Both requesters continuously: alternating grants, one result per cycle.
    for (int i = 0; i < 10; i++) begin
      rand_req(0, 1'b1);
      rand_req(1, 1'b1);
      step();
    end
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    repeat (4) step();
    exact_phase = 1'b0;

    // Backpressure with both stages full, then release.
    res_ready = 1'b0;
    rand_req(0, 1'b1); rand_req(1, 1'b1);
    repeat (5) step();
    res_ready = 1'b1;
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    repeat (4) step();

    // Flush with both stages full.
    res_ready = 1'b0;
    rand_req(0, 1'b1); rand_req(1, 1'b1);
    repeat (2) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 1'b0);
    check("flush_res_valid", res_valid, 1'b0);
    check("flush_alu_op", alu_op_alu, 12'h000);
    step();

    // Request with no ALU op still flows through.
    res_ready = 1'b1;
    exact_phase = 1'b1;
    rand_req(0, 1'b1);
    r_op[0] = 12'h000;
    step();
    r_valid[0] = 1'b0;
    step();
    check("nop_valid", res_valid, 1'b1);
    check("nop_wen_data", {res_wen, res_data}, 33'd0);
    repeat (3) step();
    exact_phase = 1'b0;

    // Randomized traffic with backpressure, flushes and resets.
    for (int i = 0; i < 400; i++) begin
      rand_req(0, $urandom_range(0, 3) != 0);
      rand_req(1, $urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0;

    // Reset while busy, then a simultaneous request goes to requester 0.
    res_ready = 1'b0;
    rand_req(0, 1'b1); rand_req(1, 1'b1);
    repeat (2) step();
    rst = 1'b1;
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst2_busy", {busy, res_valid}, 2'b00);
    check("rst2_res", {res_data, res_wen, res_rd_idx, res_src}, '0);
    check("rst2_alu_op", alu_op_alu, 12'h000);
    step();
    res_ready = 1'b1;
    rand_req(0, 1'b1); rand_req(1, 1'b1);
    @(negedge clk);
    check("rst2_first_grant", {rq0_ready, rq1_ready}, 2'b10);
    step();
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;

    // Drain everything still in flight, bounded.
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    check("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
